iob_uart_rx_fifo: RTL

//  Receive-side buffer placed directly downstream of uart_core.
//  - Drains each received byte from the core: watches rx_ready_o, pulses data_read_en_i, captures rx_data_o.
//  - Stores the bytes in a FIFO so software or a DMA consumer can read bursts without losing characters between polls.
//  - Keeps an occupancy count and a sticky overflow flag for the CSR layer.

---
 rtl/iob_uart_fifo_pkg.sv | 19 +
 rtl/iob_uart_fifo_mem.sv | 33 +++
 rtl/iob_uart_rx_fifo.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/iob_uart_fifo_pkg.sv
// Shared definitions for the UART receive FIFO.
// Contents:
//   IOB_UART_RX_FIFO_DEPTH_LOG2 - default log2 of FIFO depth
//   rxf_state_e                 - drain FSM state encodings
//   RXF_HOLD_CYCLES             - cycles spent in HOLD after each POP
package iob_uart_fifo_pkg;

    localparam int IOB_UART_RX_FIFO_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        RXF_IDLE = 2'd0,
        RXF_POP  = 2'd1,
        RXF_HOLD = 2'd2
    } rxf_state_e;

    // HOLD gives uart_core time to drop rx_ready before it is sampled again.
    localparam logic [1:0] RXF_HOLD_CYCLES = 2'd2;

endpackage

// File: rtl/iob_uart_fifo_mem.sv
// Register file backing the UART receive FIFO.
// One synchronous write port, one asynchronous read port. No reset: stale
// contents are never visible because the read side masks empty slots.
// Ports:
//   clk_i    in  clock
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address
//   rdata_o  out read data (combinational)
module iob_uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iob_uart_rx_fifo.sv
// Receive-side buffer sitting directly behind uart_core.
// A small drain FSM (IDLE -> POP -> HOLD) pulls each received byte out of the
// core and pushes it into a show-ahead FIFO; a sticky flag records dropped
// bytes.
// Ports:
//   clk_i, rst_i, rst_soft_i  clock, synchronous active-high resets
//   uart_rx_ready_i/data_i    byte-available flag and data from uart_core
//   uart_read_en_o            1-cycle read strobe back to uart_core
//   rd_en_i, rd_data_o        consumer pop request and head-of-FIFO data
//   empty_o, full_o, level_o  occupancy status
//   overflow_o, clr_overflow_i sticky drop flag and its clear
// Handshake: the core holds rx_ready_i high while a byte is pending; a byte is
// taken exactly in the cycle uart_read_en_o is high. On the consumer side a
// pop happens on any cycle with rd_en_i=1 and empty_o=0; rd_data_o shows the
// head before the pop.
module iob_uart_rx_fifo
    import iob_uart_fifo_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = IOB_UART_RX_FIFO_DEPTH_LOG2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rst_soft_i,
    input  logic                  uart_rx_ready_i,
    input  logic [DATA_W-1:0]     uart_rx_data_i,
    output logic                  uart_read_en_o,
    input  logic                  rd_en_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o,
    input  logic                  clr_overflow_i
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] FULL_LEVEL = PTR_W'(2**DEPTH_LOG2);

    logic             rst;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] level;
    logic             empty, full;
    logic             pop, push, drop, slot_free, in_pop;
    rxf_state_e       state_q;
    logic [1:0]       hold_cnt_q;
    logic             read_en_q;
    logic             overflow_q;
    logic [DATA_W-1:0] mem_rdata;

    assign rst = rst_i | rst_soft_i;

    // Extra pointer bit distinguishes full from empty; modular subtraction
    // gives the occupancy directly.
    assign level = wptr_q - rptr_q;
    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);

    assign pop       = rd_en_i & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign slot_free = ~full | pop;
    assign in_pop    = (state_q == RXF_POP);
    assign push      = in_pop & slot_free & ~rst;
    assign drop      = in_pop & ~slot_free;

    assign wptr_d = wptr_q + PTR_W'(push);
    assign rptr_d = rptr_q + PTR_W'(pop);

    always_ff @(posedge clk_i) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Drain FSM; uart_read_en_o is registered and high exactly while in POP.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q    <= RXF_IDLE;
            hold_cnt_q <= '0;
            read_en_q  <= 1'b0;
        end else begin
            case (state_q)
                RXF_IDLE: begin
                    if (uart_rx_ready_i) begin
                        state_q   <= RXF_POP;
                        read_en_q <= 1'b1;
                    end
                end
                RXF_POP: begin
                    state_q    <= RXF_HOLD;
                    read_en_q  <= 1'b0;
                    hold_cnt_q <= RXF_HOLD_CYCLES - 2'd1;
                end
                RXF_HOLD: begin
                    if (hold_cnt_q == '0) begin
                        state_q <= RXF_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q   <= RXF_IDLE;
                    read_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clr_overflow_i) begin
            overflow_q <= 1'b0;
        end
    end

    iob_uart_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (uart_rx_data_i),
        .raddr_i (rptr_q[DEPTH_LOG2-1:0]),
        .rdata_o (mem_rdata)
    );

    assign uart_read_en_o = read_en_q;
    assign rd_data_o      = empty ? '0 : mem_rdata;
    assign empty_o        = empty;
    assign full_o         = full;
    assign level_o        = level;
    assign overflow_o     = overflow_q;

endmodule
